// File: rtl/dfe_ser_pkg.sv
// Shared types and helpers for the DFE sample serializer.
// SER_PARITY_EN adds one even-parity bit to the end of each frame.
package dfe_ser_pkg;

   typedef enum logic {
      StIdle  = 1'b0,
      StShift = 1'b1
   } ser_state_e;

   localparam int unsigned W_DEFAULT = 21;

   function automatic int unsigned frame_len(input int unsigned w);
`ifdef SER_PARITY_EN
      return w + 1;
`else
      return w;
`endif
   endfunction

endpackage

// File: rtl/dfe_ser_fifo.sv
// Synchronous DEPTH-word FIFO with a combinational head word and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module dfe_ser_fifo #(
   parameter int unsigned W     = 21,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [W-1:0]  i_wdata,
   output logic [W-1:0]  o_rdata,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_level
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/dfe_sample_serializer.sv
// Buffers DFE samples and shifts each one out MSB-first with a frame-sync pulse.
// Define SER_PARITY_EN to append an even-parity bit after the LSB of each frame.
module dfe_sample_serializer
   import dfe_ser_pkg::*;
#(
   parameter int unsigned W     = W_DEFAULT,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_enable,
   input  logic [W-1:0]  i_din,
   input  logic          i_din_valid,
   input  logic          i_ovf_clr,
   output logic          o_sdout,
   output logic          o_fsync,
   output logic          o_busy,
   output logic          o_ovf,
   output logic [AW:0]   o_level
);

   localparam int unsigned FL = frame_len(W);
   localparam int unsigned CW = $clog2(FL);

   ser_state_e    r_state;
   logic [FL-1:0] r_shreg;
   logic [CW-1:0] r_cnt;
   logic          r_first;
   logic          r_sdout;
   logic          r_fsync;
   logic          r_busy;
   logic          r_ovf;

   logic          w_full;
   logic          w_empty;
   logic [W-1:0]  w_head;
   logic          w_push;
   logic          w_pop;
   logic          w_drop;
   logic [FL-1:0] w_load;

   assign w_push = i_din_valid & i_enable;
   // Pop only at a frame boundary: from idle, or on the last bit of the current frame.
   assign w_pop  = i_enable & ~w_empty & ((r_state == StIdle) | (r_cnt == '0));
   assign w_drop = w_push & w_full & ~w_pop;

`ifdef SER_PARITY_EN
   assign w_load = {w_head, ^w_head};
`else
   assign w_load = w_head;
`endif

   dfe_ser_fifo #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (i_din),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (o_level)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_first <= 1'b0;
         r_sdout <= 1'b0;
         r_fsync <= 1'b0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
         end
         case (r_state)
            StIdle: begin
               r_sdout <= 1'b0;
               r_fsync <= 1'b0;
               r_busy  <= 1'b0;
               if (w_pop) begin
                  r_shreg <= w_load;
                  r_cnt   <= CW'(FL - 1);
                  r_first <= 1'b1;
                  r_state <= StShift;
               end
            end
            StShift: begin
               r_sdout <= r_shreg[FL-1];
               r_fsync <= r_first;
               r_busy  <= 1'b1;
               r_first <= 1'b0;
               if (r_cnt == '0) begin
                  if (w_pop) begin
                     r_shreg <= w_load;
                     r_cnt   <= CW'(FL - 1);
                     r_first <= 1'b1;
                  end else begin
                     r_state <= StIdle;
                  end
               end else begin
                  r_shreg <= {r_shreg[FL-2:0], 1'b0};
                  r_cnt   <= r_cnt - CW'(1);
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_sdout = r_sdout;
   assign o_fsync = r_fsync;
   assign o_busy  = r_busy;
   assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_dfe_sample_serializer.sv
// Directed bench for dfe_sample_serializer; parity cases run when SER_PARITY_EN is defined.
module tb_dfe_sample_serializer;
   import dfe_ser_pkg::*;

   localparam int W  = 21;
   localparam int AW = 2;
   localparam int FL = frame_len(W);

   logic          clk;
   logic          rst;
   logic          enable;
   logic [W-1:0]  din;
   logic          din_valid;
   logic          ovf_clr;
   logic          sdout;
   logic          fsync;
   logic          busy;
   logic          ovf;
   logic [AW:0]   level;

   int n_tests;
   int n_fail;

   dfe_sample_serializer #(
      .W     (W),
      .DEPTH (4),
      .AW    (AW)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_enable    (enable),
      .i_din       (din),
      .i_din_valid (din_valid),
      .i_ovf_clr   (ovf_clr),
      .o_sdout     (sdout),
      .o_fsync     (fsync),
      .o_busy      (busy),
      .o_ovf       (ovf),
      .o_level     (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag, input logic [AW:0] exp_level);
      check({tag, " sdout"}, sdout, 1'b0);
      check({tag, " fsync"}, fsync, 1'b0);
      check({tag, " busy"},  busy,  1'b0);
      check({tag, " level"}, level, exp_level);
   endtask

   // One full frame starting on the next edge; MSB first, fsync on bit 0 only.
   task automatic frame(input string tag, input logic [FL-1:0] exp);
      for (int i = 0; i < FL; i++) begin
         tick();
         check($sformatf("%s bit%0d", tag, i), sdout, exp[FL-1-i]);
         check($sformatf("%s fsync%0d", tag, i), fsync, (i == 0));
         check($sformatf("%s busy%0d", tag, i), busy, 1'b1);
      end
   endtask

   initial begin
      logic [W-1:0] a_word;
      logic [2:0]   lvl_exp [8];
      logic         ovf_exp [8];
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      enable    = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      ovf_clr   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_idle("reset", 3'd0);
      check("reset ovf", ovf, 1'b0);
      enable = 1'b1;

`ifdef SER_PARITY_EN
      din_valid = 1'b1;
      din       = 21'h000007;
      tick();
      din       = 21'h000003;
      tick();
      din_valid = 1'b0;
      frame("par7", {21'h000007, 1'b1});
      frame("par3", {21'h000003, 1'b0});
      tick();
      check_idle("par idle", 3'd0);
`else
      // Single sample: accept, pop, then MSB with fsync.
      din_valid = 1'b1;
      din       = 21'h155555;
      tick();
      din_valid = 1'b0;
      check("single level accept", level, 3'd1);
      check("single sdout accept", sdout, 1'b0);
      tick();
      check_idle("single pop", 3'd0);
      frame("single", 21'h155555);
      tick();
      check_idle("single end", 3'd0);

      // Back-to-back frames, fsync 21 cycles apart.
      din_valid = 1'b1;
      din       = 21'h100000;
      tick();
      check("b2b level0", level, 3'd1);
      din = 21'h000001;
      tick();
      check("b2b level1", level, 3'd1);
      din_valid = 1'b0;
      frame("b2b0", 21'h100000);
      frame("b2b1", 21'h000001);
      tick();
      check_idle("b2b end", 3'd0);

      // Overflow: valid 8 cycles; clr on the 7th cycle collides with a drop.
      lvl_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
      ovf_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      din_valid = 1'b1;
      din       = 21'h0ABCDE;
      for (int i = 0; i < 8; i++) begin
         ovf_clr = (i == 6);
         tick();
         check($sformatf("ovf level%0d", i), level, lvl_exp[i]);
         check($sformatf("ovf flag%0d", i), ovf, ovf_exp[i]);
      end
      din_valid = 1'b0;
      ovf_clr   = 1'b1;
      tick();
      check("ovf cleared", ovf, 1'b0);
      ovf_clr   = 1'b0;
      din_valid = 1'b1;
      tick();
      check("ovf reset", ovf, 1'b1);
      din_valid = 1'b0;
      rst       = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst midframe", 3'd0);
      check("rst midframe ovf", ovf, 1'b0);

      // Enable drop at bit 10 with two words queued.
      a_word    = 21'h0F0F0F;
      din_valid = 1'b1;
      din       = a_word;
      tick();
      din = 21'h012345;
      tick();
      din = 21'h1E0011;
      for (int i = 0; i < W; i++) begin
         if (i == 1) din_valid = 1'b0;
         if (i == 10) enable = 1'b0;
         tick();
         check($sformatf("endrop bit%0d", i), sdout, a_word[W-1-i]);
      end
      tick();
      check_idle("endrop idle", 3'd2);
      din_valid = 1'b1;
      din       = 21'h1FFFFF;
      tick();
      tick();
      din_valid = 1'b0;
      check("endrop ignored level", level, 3'd2);
      check("endrop ignored ovf", ovf, 1'b0);
      enable = 1'b1;
      tick();
      check("resume pop level", level, 3'd1);
      frame("resume", 21'h012345);
      check("resume level", level, 3'd0);

      // Reset at bit 5 of the following frame.
      a_word = 21'h1E0011;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("rst5 bit%0d", i), sdout, a_word[W-1-i]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst bit5", 3'd0);
      check("rst bit5 ovf", ovf, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
